// File: rtl/emu_io_pkg.sv
// emu_io_pkg: shared types and constants for the emulation pad-side I/O bridge.
//   rst_state_e   - core reset sequencer states
//   LOSS_CNT_W    - width of the saturating PLL lock-loss counter
//   DEF_*         - default values for the bridge parameters
package emu_io_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      HOLD      = 2'd1,
      RUN       = 2'd2
   } rst_state_e;

   localparam int unsigned LOSS_CNT_W = 8;

   localparam int unsigned DEF_DATA_W       = 8;
   localparam int unsigned DEF_CTRL_IN_W    = 5;
   localparam int unsigned DEF_CTRL_OUT_W   = 2;
   localparam int unsigned DEF_SYNC_STAGES  = 2;
   localparam int unsigned DEF_OUT_STAGES   = 2;
   localparam int unsigned DEF_SW_N         = 2;
   localparam int unsigned DEF_DEBOUNCE_CNT = 65535;
   localparam int unsigned DEF_RST_HOLD     = 16;

endpackage

// File: rtl/emu_sync.sv
// emu_sync: WIDTH-bit, DEPTH-stage flop chain used as a multi-flop synchroniser.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears every stage
//   d     - asynchronous input
//   q     - synchronised output (DEPTH cycles of latency)
module emu_sync #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] chain [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) chain[i] <= '0;
      end else begin
         chain[0] <= d;
         for (int unsigned i = 1; i < DEPTH; i++) chain[i] <= chain[i-1];
      end
   end

   assign q = chain[DEPTH-1];

endmodule

// File: rtl/emu_io_bridge.sv
// emu_io_bridge: pad-side I/O bridge for FPGA emulation of the hashing core.
// Synchronises host inputs, registers core outputs to the pads, debounces
// switches and sequences the core reset from PLL lock.
// Ports:
//   clk, rst_n                    - bridge clock, async active-low reset
//   pll_lock_i                    - PLL locked (asynchronous)
//   data_i, ctrl_i                - host pads -> data_o, ctrl_o (SYNC_STAGES latency)
//   hash_i, hash_ctrl_i           - core outputs -> pad_hash_o, pad_hash_ctrl_o
//                                   (OUT_STAGES latency, held at 0 during core reset)
//   sw_i -> sw_o                  - raw / debounced switches
//   core_rst_n_o                  - registered active-low core reset
//   lock_loss_cnt_o               - saturating count of lock losses while running
// Build option: define BRIDGE_LOOPBACK_EN to add loopback_i, which routes the
// synchronised host data to the pad pipeline for PIO bring-up.
module emu_io_bridge
   import emu_io_pkg::*;
#(
   parameter int unsigned DATA_W       = DEF_DATA_W,
   parameter int unsigned CTRL_IN_W    = DEF_CTRL_IN_W,
   parameter int unsigned CTRL_OUT_W   = DEF_CTRL_OUT_W,
   parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
   parameter int unsigned OUT_STAGES   = DEF_OUT_STAGES,
   parameter int unsigned SW_N         = DEF_SW_N,
   parameter int unsigned DEBOUNCE_CNT = DEF_DEBOUNCE_CNT,
   parameter int unsigned RST_HOLD     = DEF_RST_HOLD
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pll_lock_i,
`ifdef BRIDGE_LOOPBACK_EN
   input  logic                  loopback_i,
`endif
   input  logic [DATA_W-1:0]     data_i,
   input  logic [CTRL_IN_W-1:0]  ctrl_i,
   input  logic [SW_N-1:0]       sw_i,
   input  logic [DATA_W-1:0]     hash_i,
   input  logic [CTRL_OUT_W-1:0] hash_ctrl_i,
   output logic [DATA_W-1:0]     data_o,
   output logic [CTRL_IN_W-1:0]  ctrl_o,
   output logic [DATA_W-1:0]     pad_hash_o,
   output logic [CTRL_OUT_W-1:0] pad_hash_ctrl_o,
   output logic [SW_N-1:0]       sw_o,
   output logic                  core_rst_n_o,
   output logic [LOSS_CNT_W-1:0] lock_loss_cnt_o
);

   localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);
   localparam int unsigned DB_W   = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CNT - 1);

   // ---------------- input synchronisers ----------------
   logic            lock_s;
   logic [SW_N-1:0] sw_s;

   emu_sync #(.WIDTH(DATA_W),    .DEPTH(SYNC_STAGES)) u_data_sync (.clk(clk), .rst_n(rst_n), .d(data_i),     .q(data_o));
   emu_sync #(.WIDTH(CTRL_IN_W), .DEPTH(SYNC_STAGES)) u_ctrl_sync (.clk(clk), .rst_n(rst_n), .d(ctrl_i),     .q(ctrl_o));
   emu_sync #(.WIDTH(1),         .DEPTH(SYNC_STAGES)) u_lock_sync (.clk(clk), .rst_n(rst_n), .d(pll_lock_i), .q(lock_s));
   emu_sync #(.WIDTH(SW_N),      .DEPTH(SYNC_STAGES)) u_sw_sync   (.clk(clk), .rst_n(rst_n), .d(sw_i),       .q(sw_s));

   // ---------------- core reset sequencer ----------------
   rst_state_e            state_q, state_d;
   logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
   logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;
   logic                  core_rst_q;

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      loss_cnt_d = loss_cnt_q;
      case (state_q)
         WAIT_LOCK: begin
            hold_cnt_d = '0;
            if (lock_s) state_d = HOLD;
         end
         HOLD: begin
            if (!lock_s) begin
               state_d    = WAIT_LOCK;
               hold_cnt_d = '0;
            end else if (hold_cnt_q == HOLD_LAST) begin
               state_d    = RUN;
               hold_cnt_d = '0;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         RUN: begin
            if (!lock_s) begin
               state_d = WAIT_LOCK;
               if (loss_cnt_q != '1) loss_cnt_d = loss_cnt_q + 1'b1;
            end
         end
         default: state_d = WAIT_LOCK;
      endcase
   end

   // core reset is a dedicated flop tracking the next state, so it is
   // high exactly while the registered state is RUN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= WAIT_LOCK;
         hold_cnt_q <= '0;
         loss_cnt_q <= '0;
         core_rst_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         loss_cnt_q <= loss_cnt_d;
         core_rst_q <= (state_d == RUN);
      end
   end

   assign core_rst_n_o    = core_rst_q;
   assign lock_loss_cnt_o = loss_cnt_q;

   // ---------------- output pipeline ----------------
   logic [DATA_W-1:0]     hash_src;
   logic [CTRL_OUT_W-1:0] hctrl_src;

`ifdef BRIDGE_LOOPBACK_EN
   logic loopback_s;

   emu_sync #(.WIDTH(1), .DEPTH(SYNC_STAGES)) u_lb_sync (.clk(clk), .rst_n(rst_n), .d(loopback_i), .q(loopback_s));

   always_comb begin
      hash_src  = hash_i;
      hctrl_src = hash_ctrl_i;
      if (loopback_s) begin
         hash_src  = data_o;
         hctrl_src = '0;
      end
   end
`else
   assign hash_src  = hash_i;
   assign hctrl_src = hash_ctrl_i;
`endif

   logic [DATA_W-1:0]     hash_pipe  [OUT_STAGES];
   logic [CTRL_OUT_W-1:0] hctrl_pipe [OUT_STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < OUT_STAGES; i++) begin
            hash_pipe[i]  <= '0;
            hctrl_pipe[i] <= '0;
         end
      end else if (!core_rst_q) begin
         // pads read zero while the core is held in reset
         for (int unsigned i = 0; i < OUT_STAGES; i++) begin
            hash_pipe[i]  <= '0;
            hctrl_pipe[i] <= '0;
         end
      end else begin
         hash_pipe[0]  <= hash_src;
         hctrl_pipe[0] <= hctrl_src;
         for (int unsigned i = 1; i < OUT_STAGES; i++) begin
            hash_pipe[i]  <= hash_pipe[i-1];
            hctrl_pipe[i] <= hctrl_pipe[i-1];
         end
      end
   end

   assign pad_hash_o      = hash_pipe[OUT_STAGES-1];
   assign pad_hash_ctrl_o = hctrl_pipe[OUT_STAGES-1];

   // ---------------- switch debounce ----------------
   for (genvar g = 0; g < SW_N; g++) begin : g_db
      logic [DB_W-1:0] cnt_q;
      logic            sw_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q <= '0;
            sw_q  <= 1'b0;
         end else if (sw_s[g] == sw_q) begin
            cnt_q <= '0;
         end else if (cnt_q == DB_LAST) begin
            sw_q  <= sw_s[g];
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end

      assign sw_o[g] = sw_q;
   end

endmodule
